// File: rtl/uart_transmit_controller_pkg.sv
// Shared UART definitions: bit-period constants and controller state types
// used by both the receive and transmit controllers.
package uart_transmit_controller_pkg;

    localparam int CLOCKS_PER_BIT_DEFAULT = 434;
    localparam int CLOCKS_PER_BIT_SIM     = 6;
    localparam int FRAME_BITS             = 10;

    typedef enum logic [2:0] {
        S_RXC_IDLE,
        S_RXC_START_BIT,
        S_RXC_DATA_BITS,
        S_RXC_STOP_BIT,
        S_RXC_CLEANUP
    } RX_Controller_state_type;

    typedef enum logic [1:0] {
        S_TXC_IDLE,
        S_TXC_START_BIT,
        S_TXC_DATA_BITS,
        S_TXC_STOP_BIT
    } TX_Controller_state_type;

    // Guard against a zero-width counter for degenerate bit periods.
    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_transmit_controller.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shift register.
// Frames run back-to-back when a byte is queued; loads while full are dropped and flag Overrun.
module uart_transmit_controller
    import uart_transmit_controller_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       Resetn,
    input  logic       Enable,
    input  logic       Load_data,
    input  logic [7:0] TX_data,
    output logic       Empty,
    output logic       Busy,
    output logic       Overrun,
    output logic       UART_TX_O
);

    localparam int               CNT_W    = cnt_width(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    TX_Controller_state_type state_q;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       hold_q, shift_q;
    logic             empty_q, busy_q, overrun_q, tx_q;
    logic             bit_end, start_xfer;

    always_comb begin
        bit_end    = (clk_cnt_q == CNT_LAST);
        clk_cnt_d  = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        // A queued byte launches from idle, or directly off the end of a stop bit.
        start_xfer = Enable && !empty_q &&
                     ((state_q == S_TXC_IDLE) || ((state_q == S_TXC_STOP_BIT) && bit_end));
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_TXC_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            hold_q    <= 8'h00;
            shift_q   <= 8'h00;
            empty_q   <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            if (Load_data) begin
                if (empty_q) begin
                    hold_q    <= TX_data;
                    empty_q   <= 1'b0;
                    overrun_q <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            if (start_xfer) begin
                shift_q   <= hold_q;
                empty_q   <= 1'b1;
                bit_cnt_q <= '0;
                clk_cnt_q <= '0;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                state_q   <= S_TXC_START_BIT;
            end else begin
                case (state_q)
                    S_TXC_IDLE: begin
                        tx_q      <= 1'b1;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end
                    S_TXC_START_BIT: begin
                        clk_cnt_q <= clk_cnt_d;
                        if (bit_end) begin
                            tx_q    <= shift_q[0];
                            state_q <= S_TXC_DATA_BITS;
                        end
                    end
                    S_TXC_DATA_BITS: begin
                        clk_cnt_q <= clk_cnt_d;
                        if (bit_end) begin
                            if (bit_cnt_q == 3'd7) begin
                                tx_q    <= 1'b1;
                                state_q <= S_TXC_STOP_BIT;
                            end else begin
                                shift_q   <= shift_q >> 1;
                                tx_q      <= shift_q[1];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    S_TXC_STOP_BIT: begin
                        clk_cnt_q <= clk_cnt_d;
                        if (bit_end) begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_TXC_IDLE;
                        end
                    end
                    default: begin
                        tx_q      <= 1'b1;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= S_TXC_IDLE;
                    end
                endcase
            end
        end
    end

    assign Empty     = empty_q;
    assign Busy      = busy_q;
    assign Overrun   = overrun_q;
    assign UART_TX_O = tx_q;

endmodule

// File: tb/tb_uart_transmit_controller.sv
// Bench for uart_transmit_controller: directed vectors and sequences plus random traffic,
// all checked against a frame-position reference model and a line decoder.
module tb_uart_transmit_controller;
    import uart_transmit_controller_pkg::*;

    localparam int CPB   = CLOCKS_PER_BIT_SIM;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       Resetn = 1'b0;
    logic       Enable = 1'b0;
    logic       Load_data = 1'b0;
    logic [7:0] TX_data = 8'h00;
    logic       Empty, Busy, Overrun, UART_TX_O;

    uart_transmit_controller #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .Enable    (Enable),
        .Load_data (Load_data),
        .TX_data   (TX_data),
        .Empty     (Empty),
        .Busy      (Busy),
        .Overrun   (Overrun),
        .UART_TX_O (UART_TX_O)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a frame is a 10-bit pattern indexed by elapsed cycles / CPB.
    bit         m_empty, m_ovr, m_active;
    logic [7:0] m_hold;
    logic [9:0] m_frame;
    int         m_pos;

    bit         line_q[$];
    bit         busy_log[$];
    logic [7:0] got_q[$];

    typedef struct {
        bit         en;
        bit         ld;
        logic [7:0] d;
        logic [3:0] exp;  // {tx, empty, busy, overrun}
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_empty  = 1'b1;
        m_ovr    = 1'b0;
        m_active = 1'b0;
        m_hold   = 8'h00;
        m_frame  = 10'h3ff;
        m_pos    = 0;
    endtask

    task automatic model_step();
        bit         ending, xfer, old_empty;
        logic [7:0] old_hold;
        if (!Resetn) begin
            model_reset();
            return;
        end
        old_hold  = m_hold;
        old_empty = m_empty;
        ending    = m_active && (m_pos == FRAME - 1);
        xfer      = Enable && !old_empty && (!m_active || ending);
        if (Load_data) begin
            if (old_empty) begin
                m_hold  = TX_data;
                m_empty = 1'b0;
                m_ovr   = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (xfer) begin
            m_frame  = {1'b1, old_hold, 1'b0};
            m_pos    = 0;
            m_active = 1'b1;
            m_empty  = 1'b1;
        end else if (m_active) begin
            if (ending) m_active = 1'b0;
            else        m_pos++;
        end
    endtask

    function automatic logic [3:0] model_out();
        logic tx;
        tx = m_active ? m_frame[m_pos / CPB] : 1'b1;
        return {tx, m_empty, m_active, m_ovr};
    endfunction

    function automatic logic [3:0] dut_out();
        return {UART_TX_O, Empty, Busy, Overrun};
    endfunction

    task automatic cycle(input bit en, input bit ld, input logic [7:0] d);
        Enable    = en;
        Load_data = ld;
        TX_data   = d;
        @(posedge clk);
        model_step();
        #1;
        check("model", {28'h0, dut_out()}, {28'h0, model_out()});
        line_q.push_back(UART_TX_O);
        busy_log.push_back(Busy);
    endtask

    task automatic run(input int n, input bit en);
        repeat (n) cycle(en, 1'b0, 8'h00);
    endtask

    task automatic clear_log();
        line_q.delete();
        busy_log.delete();
    endtask

    // Independent line decoder: find a falling edge, sample each bit mid-period.
    task automatic decode_line();
        int         i;
        logic [7:0] b;
        got_q.delete();
        i = 0;
        while (i + FRAME <= line_q.size()) begin
            if (line_q[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = line_q[i + CPB/2 + (k+1)*CPB];
                got_q.push_back(b);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_bytes(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1);
        decode_line();
        check({name, " count"}, got_q.size(), n);
        if (got_q.size() >= 1) check({name, " byte0"}, got_q[0], b0);
        if (n >= 2 && got_q.size() >= 2) check({name, " byte1"}, got_q[1], b1);
    endtask

    function automatic int longest_busy();
        int best = 0, cur = 0;
        foreach (busy_log[i]) begin
            cur = busy_log[i] ? cur + 1 : 0;
            if (cur > best) best = cur;
        end
        return best;
    endfunction

    function automatic int total_busy();
        int n = 0;
        foreach (busy_log[i]) if (busy_log[i]) n++;
        return n;
    endfunction

    initial begin
        int bad;
        vecs[0] = '{1'b1, 1'b1, 8'h11, 4'b1000};
        vecs[1] = '{1'b1, 1'b1, 8'h22, 4'b0111};
        vecs[2] = '{1'b1, 1'b1, 8'h33, 4'b0010};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 4'b0010};
        model_reset();

        // Reset state, then a long enabled idle with nothing queued.
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        check("reset state", dut_out(), 4'b1100);
        Resetn = 1'b1;
        clear_log();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (dut_out() !== 4'b1100) bad++;
        end
        check("idle100 deviations", bad, 0);

        // Single byte 0x55: exact waveform and busy length.
        clear_log();
        cycle(1'b1, 1'b1, 8'h55);
        check("55 after load", dut_out(), 4'b1000);
        cycle(1'b1, 1'b0, 8'h00);
        check("55 start bit", dut_out(), 4'b0110);
        run(70, 1'b1);
        bad = 0;
        for (int j = 0; j < FRAME; j++)
            if (line_q[1 + j] !== bit'(((j / CPB) % 2) == 1)) bad++;
        check("55 waveform errors", bad, 0);
        check("55 busy total", total_busy(), FRAME);
        check_bytes("55", 1, 8'h55, 8'h00);

        // Second byte queued during data bits: frames must abut.
        clear_log();
        cycle(1'b1, 1'b1, 8'hA3);
        run(20, 1'b1);
        cycle(1'b1, 1'b1, 8'h0F);
        run(130, 1'b1);
        check("A3/0F contiguous busy", longest_busy(), 2 * FRAME);
        check("A3/0F overrun", Overrun, 1'b0);
        check_bytes("A3/0F", 2, 8'hA3, 8'h0F);

        // Loads on consecutive idle cycles: the one colliding with the transfer is dropped.
        clear_log();
        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].ld, vecs[i].d);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end
        run(130, 1'b1);
        check_bytes("11/22/33", 2, 8'h11, 8'h33);

        // Load while disabled, then enable.
        clear_log();
        cycle(1'b0, 1'b1, 8'hC4);
        run(20, 1'b0);
        check("C4 held disabled", dut_out(), 4'b1000);
        check("C4 line idle", total_busy(), 0);
        clear_log();
        cycle(1'b1, 1'b0, 8'h00);
        check("C4 start on enable", dut_out(), 4'b0110);
        run(70, 1'b1);
        check_bytes("C4", 1, 8'hC4, 8'h00);

        // Enable dropped mid-frame with a byte queued.
        clear_log();
        cycle(1'b1, 1'b1, 8'h96);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h3C);
        run(80, 1'b0);
        check("queued while disabled", dut_out(), 4'b1000);
        run(70, 1'b1);
        check_bytes("96/3C", 2, 8'h96, 8'h3C);

        // Asynchronous reset during data bit 3.
        cycle(1'b1, 1'b1, 8'h5A);
        cycle(1'b1, 1'b0, 8'h00);
        run(26, 1'b1);
        check("pre-reset busy", Busy, 1'b1);
        Resetn = 1'b0;
        #1;
        check("async reset", dut_out(), 4'b1100);
        model_reset();
        repeat (2) cycle(1'b1, 1'b0, 8'h00);
        Resetn = 1'b1;
        clear_log();
        cycle(1'b1, 1'b1, 8'h7E);
        run(70, 1'b1);
        check_bytes("7E after reset", 1, 8'h7E, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
